// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_chain register pipeline.
package pipe_pkg;

  localparam int PIPE_MIN_DEPTH = 1;

  // Occupancy must be able to represent every count from 0 up to a full chain.
  function automatic int clog2_occ(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One ready/valid register stage; 1-cycle latency, loads when empty or when downstream takes its word.
// ready_up is the raw combinational ready; the caller masks it with en/sclr/aclr at the chain boundary.
module pipe_stage #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             en,
  input  logic             sclr,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready_up
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t st_q, st_d;

  assign ready_up = ~st_q.valid | down_ready;

  // Data only moves with a valid word, so bubbles never toggle the data flops.
  always_comb begin
    st_d = st_q;
    if (sclr) begin
      st_d.valid = 1'b0;
      st_d.data  = RESET_VALUE;
    end else if (en && ready_up) begin
      st_d.valid = up_valid;
      if (up_valid) begin
        st_d.data = up_data;
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      st_q.valid <= 1'b0;
      st_q.data  <= RESET_VALUE;
    end else begin
      st_q <= st_d;
    end
  end

  assign valid = st_q.valid;
  assign data  = st_q.data;

endmodule

// File: rtl/pipe_chain.sv
// DEPTH-stage ready/valid register chain, DEPTH-cycle latency, bubbles collapse under stall, ready ripples combinationally.
// en=0 or sclr masks both handshakes; optional registered occupancy count under PIPE_OCCUPANCY_EN.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             en,
  input  logic             sclr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [clog2_occ(DEPTH)-1:0] occupancy
`endif
);

  if (DEPTH < PIPE_MIN_DEPTH) begin : g_bad_depth
    $error("pipe_chain: DEPTH must be at least %0d", PIPE_MIN_DEPTH);
  end

  logic run;
  assign run = en & ~sclr;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid_w;
    logic [WIDTH-1:0] up_data_w;
    logic             down_ready_w;
    logic             valid_w;
    logic [WIDTH-1:0] data_w;
    logic             ready_w;

    if (i == 0) begin : g_head
      assign up_valid_w = in_valid;
      assign up_data_w  = in_data;
    end else begin : g_link
      assign up_valid_w = g_stage[i-1].valid_w;
      assign up_data_w  = g_stage[i-1].data_w;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign down_ready_w = out_ready;
    end else begin : g_mid
      assign down_ready_w = g_stage[i+1].ready_w;
    end

    pipe_stage #(
      .WIDTH      (WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_stage (
      .clk       (clk),
      .aclr      (aclr),
      .en        (en),
      .sclr      (sclr),
      .up_valid  (up_valid_w),
      .up_data   (up_data_w),
      .down_ready(down_ready_w),
      .valid     (valid_w),
      .data      (data_w),
      .ready_up  (ready_w)
    );
  end

  // Raw stage ready is 1 while flops sit in reset, so aclr must gate it here.
  assign in_ready  = g_stage[0].ready_w & run & ~aclr;
  assign out_valid = g_stage[DEPTH-1].valid_w & run;
  assign out_data  = g_stage[DEPTH-1].data_w;

`ifdef PIPE_OCCUPANCY_EN
  localparam int OCC_W = clog2_occ(DEPTH);

  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (sclr) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_valid & in_ready) - OCC_W'(out_valid & out_ready);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (WIDTH=8, DEPTH=3, RESET_VALUE=0); inputs change 1ns after posedge, outputs checked 2ns after.
module tb_pipe_chain;

  logic       clk;
  logic       aclr;
  logic       en;
  logic       sclr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef PIPE_OCCUPANCY_EN
  logic [1:0] occupancy;
`endif

  int n_chk = 0;
  int n_err = 0;

  pipe_chain #(
    .WIDTH      (8),
    .DEPTH      (3),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk      (clk),
    .aclr     (aclr),
    .en       (en),
    .sclr     (sclr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input int exp);
`ifdef PIPE_OCCUPANCY_EN
    chk(tag, 32'(occupancy), 32'(exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_out [6];
    logic       exp_vld [6];

    aclr = 1'b1; en = 1'b1; sclr = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk_occ("rst_occ", 0);
    tick();
    aclr = 1'b0;

    // Free flow: words emerge three edges after acceptance.
    exp_vld = '{0, 0, 0, 1, 1, 1};
    exp_out = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: drive(1'b1, 8'h11, 1'b1);
        1: drive(1'b1, 8'h22, 1'b1);
        2: drive(1'b1, 8'h33, 1'b1);
        default: drive(1'b0, 8'h00, 1'b1);
      endcase
      chk($sformatf("flow_in_ready_%0d", k), in_ready, 1);
      chk($sformatf("flow_out_valid_%0d", k), out_valid, exp_vld[k]);
      if (exp_vld[k]) chk($sformatf("flow_out_data_%0d", k), out_data, exp_out[k]);
      tick();
    end
    chk("flow_drained", out_valid, 0);

    // Stall fill, then release with a simultaneous in/out transfer.
    drive(1'b1, 8'hA1, 1'b0); chk("stall_rdy_a1", in_ready, 1); tick();
    drive(1'b1, 8'hA2, 1'b0); chk("stall_rdy_a2", in_ready, 1); tick();
    drive(1'b1, 8'hA3, 1'b0); chk("stall_rdy_a3", in_ready, 1); tick();
    drive(1'b1, 8'hA4, 1'b0);
    chk("stall_full_rdy", in_ready, 0);
    chk("stall_head_vld", out_valid, 1);
    chk("stall_head_dat", out_data, 8'hA1);
    chk_occ("stall_occ", 3);
    drive(1'b1, 8'hA4, 1'b1);
    chk("release_rdy", in_ready, 1);
    chk("release_dat", out_data, 8'hA1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("rel_a2", out_data, 8'hA2); tick();
    chk("rel_a3", out_data, 8'hA3); tick();
    chk("rel_a4", out_data, 8'hA4);
    chk("rel_a4_vld", out_valid, 1); tick();
    chk("rel_empty", out_valid, 0);
    chk_occ("rel_occ", 0);

    // Bubble between two words collapses while the output is stalled.
    drive(1'b1, 8'h01, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    drive(1'b1, 8'h02, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    tick();
    chk_occ("bub_occ", 2);
    chk("bub_in_ready", in_ready, 1);
    chk("bub_head_vld", out_valid, 1);
    drive(1'b0, 8'h00, 1'b1);
    chk("bub_out_01", out_data, 8'h01); tick();
    chk("bub_vld_02", out_valid, 1);
    chk("bub_out_02", out_data, 8'h02); tick();
    chk("bub_empty", out_valid, 0);

    // Synchronous clear with two words held and a word offered.
    drive(1'b1, 8'hB1, 1'b0); tick();
    drive(1'b1, 8'hB2, 1'b0); tick();
    drive(1'b1, 8'hB3, 1'b1);
    sclr = 1'b1;
    #1;
    chk("sclr_in_ready", in_ready, 0);
    chk("sclr_out_valid", out_valid, 0);
    tick();
    sclr = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    chk_occ("sclr_occ", 0);
    chk("sclr_after_rdy", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sclr_no_word_%0d", k), out_valid, 0);
      tick();
    end

    // Freeze a full chain with en=0, then resume in order.
    drive(1'b1, 8'hC1, 1'b0); tick();
    drive(1'b1, 8'hC2, 1'b0); tick();
    drive(1'b1, 8'hC3, 1'b0); tick();
    en = 1'b0;
    drive(1'b1, 8'hC4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("frz_in_ready_%0d", k), in_ready, 0);
      chk($sformatf("frz_out_valid_%0d", k), out_valid, 0);
      chk_occ($sformatf("frz_occ_%0d", k), 3);
      tick();
    end
    en = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    chk("res_vld", out_valid, 1);
    chk("res_c1", out_data, 8'hC1); tick();
    chk("res_c2", out_data, 8'hC2); tick();
    chk("res_c3", out_data, 8'hC3); tick();
    chk("res_empty", out_valid, 0);

    // Asynchronous clear mid-stream, checked before any clock edge.
    drive(1'b1, 8'hD1, 1'b0); tick();
    drive(1'b1, 8'hD2, 1'b0); tick();
    drive(1'b1, 8'hD3, 1'b0); tick();
    chk("aclr_pre_vld", out_valid, 1);
    chk("aclr_pre_dat", out_data, 8'hD1);
    aclr = 1'b1;
    #1;
    chk("aclr_out_valid", out_valid, 0);
    chk("aclr_out_data", out_data, 8'h00);
    chk("aclr_in_ready", in_ready, 0);
    chk_occ("aclr_occ", 0);
    tick();
    aclr = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    chk("aclr_post_vld", out_valid, 0);
    chk("aclr_post_rdy", in_ready, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
